// File: rtl/set_pkg.sv
// Shared definitions for the set-scan counter: mode encodings, FSM states,
// grid defaults and the squared-distance helpers used by the point evaluator.
package set_pkg;

    localparam int COORD_W      = 4;
    localparam int DEF_GRID_MIN = 1;
    localparam int DEF_GRID_MAX = 8;
    localparam int DEF_CNT_W    = 8;

    typedef enum logic [1:0] {
        SET_A   = 2'b00,
        SET_AND = 2'b01,
        SET_XOR = 2'b10,
        SET_OR  = 2'b11
    } set_mode_e;

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } scan_state_e;

    // |p-c| fits in 4 bits, so squaring the magnitude gives the exact 8-bit square.
    function automatic logic [8:0] dist_sq(input logic [COORD_W-1:0] px,
                                           input logic [COORD_W-1:0] py,
                                           input logic [COORD_W-1:0] cx,
                                           input logic [COORD_W-1:0] cy);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        logic [7:0]         sx;
        logic [7:0]         sy;
        dx = (px >= cx) ? (px - cx) : (cx - px);
        dy = (py >= cy) ? (py - cy) : (cy - py);
        sx = {4'b0000, dx} * {4'b0000, dx};
        sy = {4'b0000, dy} * {4'b0000, dy};
        return {1'b0, sx} + {1'b0, sy};
    endfunction

    function automatic logic [8:0] r_sq(input logic [COORD_W-1:0] r);
        logic [7:0] s;
        s = {4'b0000, r} * {4'b0000, r};
        return {1'b0, s};
    endfunction

endpackage

// File: rtl/set_point_eval.sv
// Combinational membership test of one grid point against circles A and B,
// combined according to the selected set mode.
module set_point_eval
    import set_pkg::*;
(
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] xa,
    input  logic [COORD_W-1:0] ya,
    input  logic [COORD_W-1:0] ra,
    input  logic [COORD_W-1:0] xb,
    input  logic [COORD_W-1:0] yb,
    input  logic [COORD_W-1:0] rb,
    input  set_mode_e          mode,
    output logic               hit
);

    logic in_a;
    logic in_b;

    assign in_a = (dist_sq(x, y, xa, ya) <= r_sq(ra));
    assign in_b = (dist_sq(x, y, xb, yb) <= r_sq(rb));

    always_comb begin
        hit = 1'b0;
        case (mode)
            SET_A:   hit = in_a;
            SET_AND: hit = in_a & in_b;
            SET_XOR: hit = in_a ^ in_b;
            SET_OR:  hit = in_a | in_b;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/set_scan_ctrl.sv
// Sequenced set-element counter: latches two circles and a mode, scans the
// grid one point per clock through a shared evaluator and reports the count.
module set_scan_ctrl
    import set_pkg::*;
#(
    parameter int GRID_MIN = DEF_GRID_MIN,
    parameter int GRID_MAX = DEF_GRID_MAX,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [23:0]      central,
    input  logic [11:0]      radius,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] candidate
);

    localparam logic [COORD_W-1:0] C_MIN = COORD_W'(GRID_MIN);
    localparam logic [COORD_W-1:0] C_MAX = COORD_W'(GRID_MAX);

    scan_state_e        state_q, state_d;
    logic               load;
    logic               last;
    logic [COORD_W-1:0] xa_q, ya_q, ra_q, xb_q, yb_q, rb_q;
    set_mode_e          mode_q;
    logic [COORD_W-1:0] x_q, y_q;
    logic [CNT_W-1:0]   acc_q;
    logic [CNT_W-1:0]   acc_next;
    logic               hit;
    logic               unused_bits;

    assign unused_bits = ^{central[7:0], radius[3:0]};

    set_point_eval u_eval (
        .x    (x_q),
        .y    (y_q),
        .xa   (xa_q),
        .ya   (ya_q),
        .ra   (ra_q),
        .xb   (xb_q),
        .yb   (yb_q),
        .rb   (rb_q),
        .mode (mode_q),
        .hit  (hit)
    );

    assign acc_next = acc_q + CNT_W'(hit);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_SCAN;
                    load    = 1'b1;
                end
            end
            ST_SCAN: begin
                if ((x_q == C_MAX) && (y_q == C_MAX)) begin
                    state_d = ST_IDLE;
                    last    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operands are captured once at job start so host changes mid-scan are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xa_q      <= '0;
            ya_q      <= '0;
            ra_q      <= '0;
            xb_q      <= '0;
            yb_q      <= '0;
            rb_q      <= '0;
            mode_q    <= SET_A;
            x_q       <= C_MIN;
            y_q       <= C_MIN;
            acc_q     <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            candidate <= '0;
        end else begin
            valid <= 1'b0;
            if (load) begin
                xa_q   <= central[23:20];
                ya_q   <= central[19:16];
                xb_q   <= central[15:12];
                yb_q   <= central[11:8];
                ra_q   <= radius[11:8];
                rb_q   <= radius[7:4];
                mode_q <= set_mode_e'(mode);
                x_q    <= C_MIN;
                y_q    <= C_MIN;
                acc_q  <= '0;
                busy   <= 1'b1;
            end else if (state_q == ST_SCAN) begin
                acc_q <= acc_next;
                if (y_q == C_MAX) begin
                    y_q <= C_MIN;
                    x_q <= x_q + 1'b1;
                end else begin
                    y_q <= y_q + 1'b1;
                end
                if (last) begin
                    candidate <= acc_next;
                    valid     <= 1'b1;
                    busy      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_set_scan_ctrl.sv
// Self-checking bench for set_scan_ctrl: table of jobs with a scoreboard of
// expected counts, plus back-to-back and mid-scan reset sequences.
module tb_set_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
    logic        busy;
    logic        valid;
    logic [7:0]  candidate;

    typedef struct {
        logic [23:0] central;
        logic [11:0] radius;
        logic [1:0]  mode;
        int          expCount;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   expQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;

    set_scan_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .central   (central),
        .radius    (radius),
        .mode      (mode),
        .busy      (busy),
        .valid     (valid),
        .candidate (candidate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [23:0] mkCentral(input int xa, input int ya, input int xb, input int yb);
        return {4'(xa), 4'(ya), 4'(xb), 4'(yb), 8'hA5};
    endfunction

    function automatic logic [11:0] mkRadius(input int ra, input int rb);
        return {4'(ra), 4'(rb), 4'h9};
    endfunction

    task automatic addVec(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                          input int e, input string n);
        vec_t v;
        v.central  = c;
        v.radius   = r;
        v.mode     = m;
        v.expCount = e;
        v.name     = n;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit holdEn);
        @(negedge clk);
        central = v.central;
        radius  = v.radius;
        mode    = v.mode;
        en      = 1'b1;
        expQ.push_back(v.expCount);
        @(negedge clk);
        en = holdEn;
    endtask

    // Samples on falling edges until valid appears, counting busy cycles on the way.
    task automatic waitForResult(output int busyCycles, output bit got);
        busyCycles = 0;
        got        = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (valid) begin
                got = 1'b1;
                break;
            end
            if (busy) busyCycles++;
            @(negedge clk);
        end
    endtask

    task automatic checkResult(input string name);
        int e;
        if (expQ.size() == 0) begin
            checkOutput({name, " scoreboard empty"}, 1, 0);
        end else begin
            e = expQ.pop_front();
            checkOutput(name, int'(candidate), e);
        end
    endtask

    task automatic runJob(input vec_t v);
        int bc;
        bit got;
        applyStimulus(v, 1'b0);
        waitForResult(bc, got);
        if (!got) begin
            checkOutput({v.name, " valid timeout"}, 0, 1);
            expQ.delete();
        end else begin
            checkResult(v.name);
            checkOutput({v.name, " busy cycles"}, bc, 64);
            checkOutput({v.name, " busy at valid"}, int'(busy), 0);
            @(negedge clk);
            checkOutput({v.name, " valid width"}, int'(valid), 0);
        end
    endtask

    initial begin
        int  bc;
        bit  got;
        int  gap;
        int  pulses;

        addVec(mkCentral(4, 4, 7, 2),   mkRadius(2, 5),   2'b00, 13, "A r2");
        addVec(mkCentral(4, 4, 4, 4),   mkRadius(2, 1),   2'b01, 5,  "A and B");
        addVec(mkCentral(4, 4, 4, 4),   mkRadius(2, 1),   2'b10, 8,  "A xor B");
        addVec(mkCentral(4, 4, 4, 4),   mkRadius(2, 1),   2'b11, 13, "A or B");
        addVec(mkCentral(8, 8, 1, 1),   mkRadius(15, 15), 2'b00, 64, "full grid");
        addVec(mkCentral(15, 15, 4, 4), mkRadius(3, 9),   2'b00, 0,  "off-grid centre");
        addVec(mkCentral(1, 1, 8, 8),   mkRadius(0, 0),   2'b11, 2,  "corners or");
        addVec(mkCentral(1, 1, 8, 8),   mkRadius(0, 0),   2'b01, 0,  "corners and");

        rst     = 1'b0;
        en      = 1'b0;
        central = '0;
        radius  = '0;
        mode    = '0;
        #12;
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset valid", int'(valid), 0);
        checkOutput("reset candidate", int'(candidate), 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) runJob(vecs[i]);

        // Back-to-back jobs with en held high, operands disturbed during the second scan.
        applyStimulus(vecs[0], 1'b1);
        expQ.push_back(vecs[0].expCount);
        waitForResult(bc, got);
        if (!got) begin
            checkOutput("b2b first valid timeout", 0, 1);
            expQ.delete();
        end else begin
            checkResult("b2b first");
            gap = 0;
            got = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                gap++;
                if (gap == 10) begin
                    central = 24'hFFFFFF;
                    radius  = 12'hFFF;
                    mode    = 2'b11;
                end
                if (gap >= 12 && gap < 30) en = ~en;
                if (gap == 30) en = 1'b1;
                if (valid) begin
                    got = 1'b1;
                    break;
                end
            end
            en = 1'b0;
            if (!got) begin
                checkOutput("b2b second valid timeout", 0, 1);
                expQ.delete();
            end else begin
                checkOutput("b2b valid spacing", gap, 65);
                checkResult("b2b second");
            end
        end
        en = 1'b0;
        @(negedge clk);

        // Reset in the middle of a scan aborts the job with no later valid.
        applyStimulus(vecs[0], 1'b0);
        repeat (30) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort valid", int'(valid), 0);
        checkOutput("abort candidate", int'(candidate), 0);
        expQ.delete();
        @(negedge clk);
        rst    = 1'b1;
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        checkOutput("no valid after abort", pulses, 0);
        runJob(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
